// File: rtl/multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : multi_tick_gen
// Description : Multi-channel programmable clock-enable generator. Each
//               channel emits a one-cycle tick every (div+1) enabled clk
//               cycles (periodic) or once per arming (one-shot). A shared
//               valid/ready config port reprograms any channel at run time.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_tick_gen #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 20,
   parameter int DEF_DIV = 833332,
   parameter int CH_W    = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync_clr,
   input  logic [NUM_CH-1:0] arm,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } ch_state_t;

   localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
   // One extra bit so NUM_CH itself is representable when NUM_CH == 2**CH_W.
   localparam logic [CH_W:0]    NUM_CH_V  = (CH_W+1)'(NUM_CH);

   logic accept;
   logic ch_out_of_range;

   assign accept          = cfg_valid & cfg_ready;
   assign ch_out_of_range = ({1'b0, cfg_ch} >= NUM_CH_V);

   // Config handshake: ready rises on the first edge out of reset; a write to
   // a nonexistent channel is dropped and flagged with a one-cycle error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_ready <= 1'b1;
         cfg_err   <= accept & ch_out_of_range;
      end
   end

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         ch_state_t        state, state_nxt;
         logic [CNT_W-1:0] cnt, cnt_nxt;
         logic [CNT_W-1:0] div, div_nxt;
         logic             mode, mode_nxt;
         logic             tick_q, tick_nxt;
         logic             cfg_hit;

         // Out-of-range indices never match because g < NUM_CH.
         assign cfg_hit = accept & (cfg_ch == CH_W'(g));

         // Channel state register: counter, divisor, mode, FSM state, tick.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state  <= ST_RUN;
               cnt    <= '0;
               div    <= DEF_DIV_V;
               mode   <= 1'b0;
               tick_q <= 1'b0;
            end else begin
               state  <= state_nxt;
               cnt    <= cnt_nxt;
               div    <= div_nxt;
               mode   <= mode_nxt;
               tick_q <= tick_nxt;
            end
         end

         // Next-state logic in priority order: config write, sync clear,
         // re-arm of a finished one-shot, terminal count, normal count, hold.
         always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            div_nxt   = div;
            mode_nxt  = mode;
            tick_nxt  = 1'b0;
            if (cfg_hit) begin
               div_nxt   = cfg_div;
               mode_nxt  = cfg_mode;
               cnt_nxt   = '0;
               state_nxt = ST_RUN;
            end else if (sync_clr) begin
               cnt_nxt = '0;
            end else if (arm[g] && (state == ST_DONE)) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else if ((state == ST_RUN) && en[g]) begin
               if (cnt == div) begin
                  cnt_nxt  = '0;
                  tick_nxt = 1'b1;
                  if (mode) begin
                     state_nxt = ST_DONE;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end

         assign tick[g] = tick_q;
         assign busy[g] = (state == ST_RUN) & en[g];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_tick_gen
// Description : Scoreboard bench for multi_tick_gen. The driver applies
//               directed and random stimulus on the falling edge and pushes
//               the expected outputs from a countdown reference model; a
//               monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_tick_gen;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 20;
   localparam int DEF_DIV = 3;
   localparam int CH_W    = 3;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NUM_CH-1:0] en;
   logic              sync_clr;
   logic [NUM_CH-1:0] arm;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_mode;
   logic              cfg_err;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] busy;

   int vectors     = 0;
   int miscompares = 0;

   // Expected {tick, busy, cfg_err, cfg_ready} for each rising edge.
   logic [2*NUM_CH+1:0] sb[$];

   // Reference model: enabled edges remaining until the next tick.
   int m_left[NUM_CH];
   int m_div[NUM_CH];
   bit m_mode[NUM_CH];
   bit m_done[NUM_CH];
   bit m_ready;

   always #5 clk = ~clk;

   multi_tick_gen #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV),
      .CH_W   (CH_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .en       (en),
      .sync_clr (sync_clr),
      .arm      (arm),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .cfg_err  (cfg_err),
      .tick     (tick),
      .busy     (busy)
   );

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i]  = DEF_DIV;
         m_left[i] = DEF_DIV + 1;
         m_mode[i] = 1'b0;
         m_done[i] = 1'b0;
      end
      m_ready = 1'b0;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue the expected
   // outputs for the following rising edge.
   task automatic step(input bit rv, input logic [NUM_CH-1:0] e, input bit sc,
                       input logic [NUM_CH-1:0] a, input bit cv,
                       input logic [CH_W-1:0] ch, input int dv, input bit md);
      logic [NUM_CH-1:0] t;
      logic [NUM_CH-1:0] b;
      bit                acc;
      bit                err;
      @(negedge clk);
      resetn    = rv;
      en        = e;
      sync_clr  = sc;
      arm       = a;
      cfg_valid = cv;
      cfg_ch    = ch;
      cfg_div   = CNT_W'(dv);
      cfg_mode  = md;
      if (!rv) begin
         model_reset();
         #1;
         check("async_reset", {tick, cfg_ready, cfg_err}, '0);
         sb.push_back({{NUM_CH{1'b0}}, e, 1'b0, 1'b0});
      end else begin
         acc = cv && m_ready;
         err = acc && (ch >= NUM_CH);
         t   = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc && (ch == i)) begin
               m_div[i]  = dv;
               m_mode[i] = md;
               m_left[i] = dv + 1;
               m_done[i] = 1'b0;
            end else if (sc) begin
               m_left[i] = m_div[i] + 1;
            end else if (a[i] && m_done[i]) begin
               m_done[i] = 1'b0;
               m_left[i] = m_div[i] + 1;
            end else if (!m_done[i] && e[i]) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  t[i]      = 1'b1;
                  m_left[i] = m_div[i] + 1;
                  if (m_mode[i]) m_done[i] = 1'b1;
               end
            end
            b[i] = !m_done[i] && e[i];
         end
         m_ready = 1'b1;
         sb.push_back({t, b, err, 1'b1});
      end
   endtask

   task automatic idle(input int n, input logic [NUM_CH-1:0] e);
      repeat (n) step(1, e, 0, '0, 0, '0, 0, 0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation.
   initial begin
      logic [2*NUM_CH+1:0] ex;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            ex = sb.pop_front();
            check("cycle", {tick, busy, cfg_err, cfg_ready}, ex);
         end
      end
   end

   // Driver: directed scenarios followed by random traffic.
   initial begin
      logic [NUM_CH-1:0] re;
      logic [NUM_CH-1:0] ra;
      resetn = 1'b0; en = '0; sync_clr = 1'b0; arm = '0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
      model_reset();
      repeat (3) step(0, '0, 0, '0, 0, '0, 0, 0);

      // Ticks on channel 0 at enabled cycles 4, 8, 12 with divisor 3.
      for (int c = 1; c <= 12; c++) begin
         step(1, 4'b0001, 0, '0, 0, '0, 0, 0);
         @(posedge clk);
         #2;
         check("s1_tick0", {31'd0, tick[0]}, {31'd0, (c % 4) == 0});
      end
      check("s1_busy0", {31'd0, busy[0]}, 32'd1);

      // Divisor 0 periodic: tick every cycle.
      step(1, 4'b0011, 0, '0, 1, 3'd1, 0, 0);
      idle(6, 4'b0011);

      // One-shot with divisor 5, then re-arm.
      step(1, 4'b0111, 0, '0, 1, 3'd2, 5, 1);
      idle(10, 4'b0111);
      step(1, 4'b0111, 0, 4'b0100, 0, '0, 0, 0);
      idle(10, 4'b0111);

      // Enable gap at cnt 4, then sync clear at cnt 8.
      step(1, 4'b0111, 0, '0, 1, 3'd0, 9, 0);
      idle(4, 4'b0111);
      idle(7, 4'b0110);
      idle(4, 4'b0111);
      step(1, 4'b0111, 1, '0, 0, '0, 0, 0);
      idle(12, 4'b0111);

      // Bad channel index, then reconfigure channel 0 on its terminal cycle.
      step(1, 4'b1111, 0, '0, 1, 3'd5, 7, 0);
      step(1, 4'b1111, 0, '0, 1, 3'd0, 3, 0);
      idle(3, 4'b1111);
      step(1, 4'b1111, 0, '0, 1, 3'd0, 2, 0);
      idle(6, 4'b1111);

      // Reset pulse mid-count.
      idle(2, 4'b1111);
      step(0, 4'b1111, 0, '0, 0, '0, 0, 0);
      idle(6, 4'b1111);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            re[i] = ($urandom_range(0, 99) < 85);
            ra[i] = ($urandom_range(0, 99) < 10);
         end
         step(($urandom_range(0, 199) != 0), re,
              ($urandom_range(0, 49) == 0), ra,
              ($urandom_range(0, 99) < 8),
              CH_W'($urandom_range(0, 5)),
              int'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)));
      end

      repeat (2) @(posedge clk);
      #3;
      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
